// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared constants and types for the I2S DAC transmitter.
//               FRAME_SLOTS : SCLK half-slots per stereo frame (64)
//               HALF_SLOTS  : slots per channel (32)
//               BIT_CNT_W   : width of the frame slot counter
//               SLOT_W      : width of the in-channel slot index
//               chan_e      : channel encoding, matches LRCK polarity
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int FRAME_SLOTS = 64;
    localparam int HALF_SLOTS  = 32;
    localparam int BIT_CNT_W   = $clog2(FRAME_SLOTS);
    localparam int SLOT_W      = $clog2(HALF_SLOTS);

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_clkdiv.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clkdiv
// Description : Divides clk down to the I2S bit clock and flags the clk in
//               which the bit clock falls.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               sclk_o - bit clock, toggles every CLK_DIV clks
//               fall_o - one-clk strobe, high in the clk whose edge drives
//                        sclk_o from 1 to 0
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkdiv #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk_o,
    output logic fall_o
);

    localparam logic [7:0] c_DIV_MAX = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;
    logic       sclk_q;
    logic       sclk_d;
    logic       w_wrap;

    always_comb begin
        w_wrap    = (div_cnt_q == c_DIV_MAX);
        div_cnt_d = w_wrap ? 8'd0 : div_cnt_q + 8'd1;
        sclk_d    = w_wrap ? ~sclk_q : sclk_q;
        // Combinational so that consumers update on the same edge as sclk.
        fall_o    = w_wrap & sclk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule : i2s_clkdiv
`default_nettype wire

// File: rtl/i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_dac_tx
// Description : Stereo I2S transmitter for an audio DAC. A 64-slot frame is
//               formed from a coherent left/right sample pair latched at the
//               start of every frame; data is MSB first with a one-slot
//               I2S delay after each LRCK edge.
// Options     : I2S_MCLK_EN - when defined, dac_mclk = clk/4; otherwise 0.
// Ports       : clk, rst_n          - clock, async active-low reset
//               enable              - 0 forces dac_sdin low
//               l_data, r_data      - samples, latched at frame start
//               sample_req          - one-clk pulse at the frame latch
//               dac_sclk, dac_lrck  - bit clock, word select (1 = right)
//               dac_sdin, dac_mclk  - serial data, master clock
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    output logic              sample_req,
    output logic              dac_sclk,
    output logic              dac_lrck,
    output logic              dac_sdin,
    output logic              dac_mclk
);

    localparam logic [BIT_CNT_W-1:0] c_BIT_CNT_RST = BIT_CNT_W'(FRAME_SLOTS - 1);
    localparam logic [31:0]          c_DATA_W32    = 32'(DATA_W);

    logic                 w_fall;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic [DATA_W-1:0]    l_sh_q;
    logic [DATA_W-1:0]    l_sh_d;
    logic [DATA_W-1:0]    r_sh_q;
    logic [DATA_W-1:0]    r_sh_d;
    logic                 lrck_q;
    logic                 sdin_q;
    logic                 req_q;

    logic                 w_frame_start;
    chan_e                w_chan;
    logic [SLOT_W-1:0]    w_slot;
    logic [31:0]          w_slot32;
    logic                 w_in_word;
    logic [DATA_W-1:0]    w_word;
    logic [DATA_W-1:0]    w_mask;
    logic                 w_bit;

    i2s_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk_o (dac_sclk),
        .fall_o (w_fall)
    );

    // Everything below describes the slot entered at the next fall, so the
    // shadow registers and the outgoing bit are decided together.
    always_comb begin
        bit_cnt_d     = bit_cnt_q + 1'b1;
        w_frame_start = (bit_cnt_d == '0);
        l_sh_d        = w_frame_start ? l_data : l_sh_q;
        r_sh_d        = w_frame_start ? r_data : r_sh_q;
        w_chan        = chan_e'(bit_cnt_d[BIT_CNT_W-1]);
        w_slot        = bit_cnt_d[SLOT_W-1:0];
        w_slot32      = 32'(w_slot);
        w_word        = (w_chan == CH_RIGHT) ? r_sh_d : l_sh_d;
        // Slot 0 carries the I2S delay bit; slots past DATA_W are padding.
        w_in_word     = (w_slot32 != 32'd0) && (w_slot32 <= c_DATA_W32);
        w_mask        = DATA_W'(1) << (c_DATA_W32 - w_slot32);
        w_bit         = w_in_word & (|(w_word & w_mask));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= c_BIT_CNT_RST;
            l_sh_q    <= '0;
            r_sh_q    <= '0;
            lrck_q    <= 1'b1;
            sdin_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (w_fall) begin
                bit_cnt_q <= bit_cnt_d;
                l_sh_q    <= l_sh_d;
                r_sh_q    <= r_sh_d;
                lrck_q    <= bit_cnt_d[BIT_CNT_W-1];
                req_q     <= w_frame_start;
                sdin_q    <= enable & w_bit;
            end else if (!enable) begin
                // Mute immediately rather than waiting for the next slot.
                sdin_q <= 1'b0;
            end
        end
    end

    assign sample_req = req_q;
    assign dac_lrck   = lrck_q;
    assign dac_sdin   = sdin_q;

`ifdef I2S_MCLK_EN
    logic [1:0] mclk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mclk_cnt_q <= 2'd0;
        end else begin
            mclk_cnt_q <= mclk_cnt_q + 2'd1;
        end
    end

    assign dac_mclk = mclk_cnt_q[1];
`else
    assign dac_mclk = 1'b0;
`endif

endmodule : i2s_dac_tx
`default_nettype wire

// File: tb/tb_i2s_dac_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_dac_tx
// Description : Directed self-checking bench for i2s_dac_tx (CLK_DIV=8,
//               DATA_W=16). Frame slot k is sampled mid-slot, 8 + 16*k clks
//               after the sample_req edge.
// Options     : I2S_MCLK_EN - selects which dac_mclk behaviour is expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_dac_tx;

    localparam int CLK_DIV = 8;
    localparam int DATA_W  = 16;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              enable  = 1'b0;
    logic [DATA_W-1:0] l_data  = '0;
    logic [DATA_W-1:0] r_data  = '0;
    logic              sample_req;
    logic              dac_sclk;
    logic              dac_lrck;
    logic              dac_sdin;
    logic              dac_mclk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] sd;
    logic [63:0] lr;
    int          per;

    i2s_dac_tx #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .l_data     (l_data),
        .r_data     (r_data),
        .sample_req (sample_req),
        .dac_sclk   (dac_sclk),
        .dac_lrck   (dac_lrck),
        .dac_sdin   (dac_sdin),
        .dac_mclk   (dac_mclk)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts clks until sample_req is seen; exp_n < 0 only checks it arrives.
    task automatic wait_req(input string tag, input int exp_n);
        int n     = 0;
        bit found = 1'b0;
        int bound = (exp_n < 0) ? 2100 : exp_n + 64;
        while (!found && n < bound) begin
            @(posedge clk);
            #1;
            n++;
            if (sample_req) found = 1'b1;
        end
        if (exp_n < 0) check_eq({tag, "_seen"}, 64'(found), 64'd1);
        else           check_eq(tag, 64'(n), 64'(exp_n));
    endtask

    // Call right after wait_req; l_data is replaced by mid_l during slot 8.
    task automatic capture_frame(input logic [15:0] mid_l, output logic [63:0] s, output logic [63:0] l);
        repeat (8) @(posedge clk);
        #1;
        s[0] = dac_sdin;
        l[0] = dac_lrck;
        for (int k = 1; k < 64; k++) begin
            repeat (16) @(posedge clk);
            #1;
            s[k] = dac_sdin;
            l[k] = dac_lrck;
            if (k == 8) l_data = mid_l;
        end
    endtask

    function automatic logic [15:0] left_word(input logic [63:0] s);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = s[1+i];
        return w;
    endfunction

    function automatic logic [15:0] right_word(input logic [63:0] s);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = s[33+i];
        return w;
    endfunction

    function automatic logic [63:0] pad_bits(input logic [63:0] s);
        logic [63:0] p = s;
        for (int i = 0; i < 16; i++) begin
            p[1+i]  = 1'b0;
            p[33+i] = 1'b0;
        end
        return p;
    endfunction

    task automatic measure_sclk(output int period);
        int   n     = 0;
        int   first = -1;
        logic prev  = dac_sclk;
        period = -1;
        while (n < 200 && period < 0) begin
            @(posedge clk);
            #1;
            n++;
            if (!prev && dac_sclk) begin
                if (first < 0) first = n;
                else           period = n - first;
            end
            prev = dac_sclk;
        end
    endtask

    task automatic check_mclk();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            v[i] = dac_mclk;
        end
`ifdef I2S_MCLK_EN
        begin
            int rises = 0;
            bit half  = 1'b1;
            for (int i = 1; i < 16; i++) if (!v[i-1] && v[i]) rises++;
            for (int i = 0; i < 14; i++) if (v[i] == v[i+2]) half = 1'b0;
            check_eq("mclk_rises_16clk", 64'(rises), 64'd4);
            check_eq("mclk_half_period_2", 64'(half), 64'd1);
        end
`else
        check_eq("mclk_const_zero", 64'(v), 64'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_sclk"}, 64'(dac_sclk), 64'd0);
        check_eq({pfx, "_lrck"}, 64'(dac_lrck), 64'd1);
        check_eq({pfx, "_sdin"}, 64'(dac_sdin), 64'd0);
        check_eq({pfx, "_req"},  64'(sample_req), 64'd0);
        check_eq({pfx, "_mclk"}, 64'(dac_mclk), 64'd0);
    endtask

    initial begin
        enable = 1'b1;
        l_data = 16'hA5C3;
        r_data = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        // Startup timing and basic serialization.
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("first_req_clk", 16);
        capture_frame(16'hA5C3, sd, lr);
        check_eq("left_A5C3", 64'(left_word(sd)), 64'hA5C3);
        check_eq("right_0001", 64'(right_word(sd)), 64'h0001);
        check_eq("pad_slots_zero", pad_bits(sd), 64'd0);
        check_eq("lrck_pattern", lr, 64'hFFFF_FFFF_0000_0000);
        wait_req("req_after_capture", 8);
        wait_req("frame_period", 1024);
        measure_sclk(per);
        check_eq("sclk_period", 64'(per), 64'd16);
        check_mclk();

        // Sample coherency: a mid-frame change waits for the next latch.
        l_data = 16'h1234;
        wait_req("req_resync", -1);
        capture_frame(16'hFFFF, sd, lr);
        check_eq("coherent_left_1234", 64'(left_word(sd)), 64'h1234);
        wait_req("req_after_capture2", 8);
        capture_frame(16'hFFFF, sd, lr);
        check_eq("next_left_FFFF", 64'(left_word(sd)), 64'hFFFF);
        check_eq("next_right_0001", 64'(right_word(sd)), 64'h0001);

        // Enable dropped mid-slot 5 of a frame whose left word is all ones.
        wait_req("req_after_capture3", 8);
        repeat (8 + 5 * 16) @(posedge clk);
        #1;
        check_eq("sdin_slot5_on", 64'(dac_sdin), 64'd1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_eq("sdin_off_1clk", 64'(dac_sdin), 64'd0);
        wait_req("req_while_disabled", -1);
        wait_req("frame_period_disabled", 1024);
        capture_frame(16'hFFFF, sd, lr);
        check_eq("disabled_frame_zero", sd, 64'd0);

        // Reset asserted in slot 40 (right channel, data bit 8).
        enable = 1'b1;
        r_data = 16'hFFFF;
        wait_req("req_after_capture4", 8);
        repeat (8 + 40 * 16) @(posedge clk);
        #1;
        check_eq("slot40_sdin", 64'(dac_sdin), 64'd1);
        check_eq("slot40_sclk", 64'(dac_sclk), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_req("restart_first_req", 16);
        capture_frame(16'hFFFF, sd, lr);
        check_eq("restart_left", 64'(left_word(sd)), 64'hFFFF);
        check_eq("restart_right", 64'(right_word(sd)), 64'hFFFF);
        wait_req("restart_after_capture", 8);
        wait_req("restart_frame_period", 1024);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_i2s_dac_tx
`default_nettype wire

// File: doc/i2s_dac_tx.md
I2S_DAC_TX -- requirements
Module: i2s_dac_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per SCLK half-period; legal values 2..255.
REQ-002 SHALL have parameter DATA_W, default 16: sample width per channel; legal values 1..31.
REQ-003 SHALL have port clk  input  1  system clock (50 MHz nominal), the only clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  high = serialize samples; low = SDIN forced 0 while clocks keep running.
REQ-006 SHALL have port l_data  input  DATA_W  left sample, two's complement, sampled at the frame latch.
REQ-007 SHALL have port r_data  input  DATA_W  right sample, two's complement, sampled at the frame latch.
REQ-008 SHALL have port sample_req  output  1  one-clk pulse marking the frame latch.
REQ-009 SHALL have port dac_sclk  output  1  I2S bit clock.
REQ-010 SHALL have port dac_lrck  output  1  word select: 0 = left, 1 = right.
REQ-011 SHALL have port dac_sdin  output  1  serial data, MSB first.
REQ-012 SHALL have port dac_mclk  output  1  master clock (see Configuration).

Function
REQ-013 SHALL keep div_cnt in 0..CLK_DIV-1; at CLK_DIV-1 it wraps to 0 and dac_sclk toggles in the same clk.
REQ-014 SHALL treat a 1->0 toggle of dac_sclk as a "fall" event; every output except dac_sclk changes only on the fall clk.
REQ-015 SHALL keep bit_cnt (6 bits, 64 slots per frame) and increment it modulo 64 on each fall; 63->0 wraps silently.
REQ-016 SHALL make dac_lrck equal bit_cnt[5] after each fall update: slots 0..31 left, 32..63 right.
REQ-017 SHALL, on the fall where bit_cnt becomes 0, latch l_data/r_data into shadow registers and assert sample_req high for exactly that one clk.
REQ-018 SHALL drive half-slot s = bit_cnt[4:0] as follows: s=0 -> 0 (one-bit I2S delay); s=1..DATA_W -> shadow bit [DATA_W-s]; s>DATA_W -> 0.
REQ-019 SHALL take right-channel bits from the right shadow register and left-channel bits from the left shadow register.
REQ-020 SHALL ignore l_data/r_data changes between latches: a frame is always transmitted from one coherent sample pair.
REQ-021 SHALL evaluate enable on the fall clk: enable=0 forces dac_sdin=0 for that slot; latching and sample_req continue regardless of enable.
REQ-022 SHALL deassert dac_sdin to 0 immediately (same clk) when enable falls mid-slot.
REQ-023 SHALL produce frame rate = f_clk / (128*CLK_DIV), i.e. 48.828 kHz at 50 MHz with CLK_DIV=8.

Reset
REQ-024 SHALL, with rst_n low, hold div_cnt=0, dac_sclk=0, bit_cnt=63, dac_lrck=1, dac_sdin=0, sample_req=0, shadows=0, dac_mclk=0.
REQ-025 SHALL make the first fall after release carry bit_cnt 63->0, so the first frame latches at the first fall, CLK_DIV*2 clks after release.
REQ-026 SHALL, when reset is asserted mid-frame, return all outputs to reset values asynchronously with no partial-word completion.

Configuration
REQ-027 SHALL, with I2S_MCLK_EN defined, drive dac_mclk = clk/4 from a free-running 2-bit counter that resets to 0.
REQ-028 SHALL, with I2S_MCLK_EN not defined, tie dac_mclk to constant 0 and omit the counter.

Structure
REQ-029 SHALL place FRAME_SLOTS=64, HALF_SLOTS=32 and the bit_cnt width constant in shared package i2s_pkg.
REQ-030 SHALL implement the div_cnt/dac_sclk/fall-event generator as sub-module i2s_clkdiv, parameterized by CLK_DIV, outputting sclk and a one-clk fall strobe.

Verification
REQ-031 SHALL verify: reset release, CLK_DIV=8 -> dac_sclk period 16 clks; first sample_req at clk 16; frame period 1024 clks.
REQ-032 SHALL verify: l_data=16'hA5C3, r_data=16'h0001 -> left slots 1..16 serialize 1010010111000011; right slots 33..48 serialize 0x0001; slots 0, 17..32 and 49..63 are 0.
REQ-033 SHALL verify: l_data changed from 16'h1234 to 16'hFFFF mid-frame -> current frame still sends 16'h1234; next frame sends 16'hFFFF.
REQ-034 SHALL verify: enable dropped during slot 5 -> dac_sdin=0 within 1 clk; sample_req keeps pulsing every 1024 clks.
REQ-035 SHALL verify: rst_n pulsed low in slot 40 -> all outputs at reset values same clk; restart timing matches REQ-031.
REQ-036 SHALL verify: build with I2S_MCLK_EN defined -> dac_mclk period 4 clks; build without it -> dac_mclk constant 0.
